// File: rtl/score_keeper_if.sv
// Connection between score_keeper and its neighbours: menu/physics controls in,
// score, overlay and rally-control flags out.
interface score_keeper_if;
    logic       enable_game;
    logic       reset_game;
    logic       floor_left;
    logic       floor_right;
    logic [4:0] score_left;
    logic [4:0] score_right;
    logic       flag_point;
    logic       freeze;
    logic       serve_left;
    logic       endgame;
    logic       winner_left;

    modport master (
        output enable_game, reset_game, floor_left, floor_right,
        input  score_left, score_right, flag_point, freeze, serve_left, endgame, winner_left
    );

    modport slave (
        input  enable_game, reset_game, floor_left, floor_right,
        output score_left, score_right, flag_point, freeze, serve_left, endgame, winner_left
    );
endinterface

// File: rtl/score_keeper.sv
// Match scoring and rally sequencing: counts points from floor contacts, holds the
// rally frozen for a fixed time after each point and decides the match winner.
module score_keeper #(
    parameter int unsigned WIN_SCORE     = 15,
    parameter int unsigned WIN_MARGIN    = 2,
    parameter int unsigned FREEZE_CYCLES = 65_000_000,
    parameter int unsigned CNT_W         = 26
) (
    input logic           clk,
    input logic           rst,
    score_keeper_if.slave bus
);

    localparam int unsigned      MARGIN_EFF = (WIN_MARGIN == 0) ? 1 : WIN_MARGIN;
    localparam logic signed [5:0] MARGIN_S  = 6'(MARGIN_EFF);
    localparam logic [4:0]       WIN_S      = 5'(WIN_SCORE);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FREEZE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StPlay, StPoint, StOver} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       sl_q, sl_d, sr_q, sr_d;
    logic             flag_q, flag_d;
    logic             freeze_q, freeze_d;
    logic             serve_q, serve_d;
    logic             endgame_q, endgame_d;
    logic             winner_q, winner_d;

    logic signed [5:0] diff_l, diff_r;
    logic              win_l, win_r;

    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction

    // Scores are already updated when the freeze expires, so judge the registered values.
    assign diff_l = $signed({1'b0, sl_q}) - $signed({1'b0, sr_q});
    assign diff_r = $signed({1'b0, sr_q}) - $signed({1'b0, sl_q});
    assign win_l  = (sl_q >= WIN_S) && (diff_l >= MARGIN_S);
    assign win_r  = (sr_q >= WIN_S) && (diff_r >= MARGIN_S);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sl_d      = sl_q;
        sr_d      = sr_q;
        flag_d    = flag_q;
        freeze_d  = freeze_q;
        serve_d   = serve_q;
        endgame_d = endgame_q;
        winner_d  = winner_q;

        case (state_q)
            StIdle: begin
                freeze_d = 1'b1;
                if (bus.enable_game) begin
                    state_d  = StPlay;
                    freeze_d = 1'b0;
                end
            end
            StPlay: begin
                if (!bus.enable_game) begin
                    state_d  = StIdle;
                    cnt_d    = '0;
                    flag_d   = 1'b0;
                    freeze_d = 1'b1;
                end else if (bus.floor_left ^ bus.floor_right) begin
                    state_d  = StPoint;
                    cnt_d    = '0;
                    flag_d   = 1'b1;
                    freeze_d = 1'b1;
                    if (bus.floor_right) begin
                        sl_d    = sat_inc(sl_q);
                        serve_d = 1'b1;
                    end else begin
                        sr_d    = sat_inc(sr_q);
                        serve_d = 1'b0;
                    end
                end
            end
            StPoint: begin
                if (!bus.enable_game) begin
                    state_d  = StIdle;
                    cnt_d    = '0;
                    flag_d   = 1'b0;
                    freeze_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    flag_d = 1'b0;
                    if (win_l || win_r) begin
                        state_d   = StOver;
                        endgame_d = 1'b1;
                        winner_d  = win_l;
                        freeze_d  = 1'b1;
                    end else begin
                        state_d  = StPlay;
                        freeze_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StOver: begin
                endgame_d = 1'b1;
                freeze_d  = 1'b1;
                flag_d    = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || bus.reset_game) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sl_q      <= '0;
            sr_q      <= '0;
            flag_q    <= 1'b0;
            freeze_q  <= 1'b1;
            serve_q   <= 1'b1;
            endgame_q <= 1'b0;
            winner_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sl_q      <= sl_d;
            sr_q      <= sr_d;
            flag_q    <= flag_d;
            freeze_q  <= freeze_d;
            serve_q   <= serve_d;
            endgame_q <= endgame_d;
            winner_q  <= winner_d;
        end
    end

    assign bus.score_left  = sl_q;
    assign bus.score_right = sr_q;
    assign bus.flag_point  = flag_q;
    assign bus.freeze      = freeze_q;
    assign bus.serve_left  = serve_q;
    assign bus.endgame     = endgame_q;
    assign bus.winner_left = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: three parameterisations share one stimulus stream and are
// compared every cycle against a behavioural match model, plus literal spot checks.
module tb_score_keeper;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, rg = 1'b0, fl = 1'b0, fr = 1'b0;

    always #5 clk = ~clk;

    score_keeper_if bus_a ();
    score_keeper_if bus_b ();
    score_keeper_if bus_c ();

    score_keeper #(.WIN_SCORE(3), .WIN_MARGIN(2), .FREEZE_CYCLES(4), .CNT_W(3)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a.slave)
    );
    score_keeper #(.WIN_SCORE(1), .WIN_MARGIN(0), .FREEZE_CYCLES(4), .CNT_W(3)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b.slave)
    );
    score_keeper #(.WIN_SCORE(31), .WIN_MARGIN(31), .FREEZE_CYCLES(1), .CNT_W(1)) dut_c (
        .clk (clk), .rst (rst), .bus (bus_c.slave)
    );

    assign bus_a.enable_game = en;
    assign bus_a.reset_game  = rg;
    assign bus_a.floor_left  = fl;
    assign bus_a.floor_right = fr;
    assign bus_b.enable_game = en;
    assign bus_b.reset_game  = rg;
    assign bus_b.floor_left  = fl;
    assign bus_b.floor_right = fr;
    assign bus_c.enable_game = en;
    assign bus_c.reset_game  = rg;
    assign bus_c.floor_left  = fl;
    assign bus_c.floor_right = fr;

    // {score_left, score_right, flag_point, freeze, serve_left, endgame, winner_left}
    logic [14:0] o_vec [3];
    assign o_vec[0] = {bus_a.score_left, bus_a.score_right, bus_a.flag_point, bus_a.freeze,
                       bus_a.serve_left, bus_a.endgame, bus_a.winner_left};
    assign o_vec[1] = {bus_b.score_left, bus_b.score_right, bus_b.flag_point, bus_b.freeze,
                       bus_b.serve_left, bus_b.endgame, bus_b.winner_left};
    assign o_vec[2] = {bus_c.score_left, bus_c.score_right, bus_c.flag_point, bus_c.freeze,
                       bus_c.serve_left, bus_c.endgame, bus_c.winner_left};

    // Model: phase 0 waiting, 1 rally, 2 frozen after point, 3 match over.
    const int p_ws [3] = '{3, 1, 31};
    const int p_wm [3] = '{2, 0, 31};
    const int p_fc [3] = '{4, 4, 1};
    int md [3], msl [3], msr [3], mserve [3], mleft [3], mwin [3];

    int checks = 0;
    int failures = 0;
    int n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int m;
        for (int i = 0; i < 3; i++) begin
            if (rst || rg) begin
                md[i] = 0; msl[i] = 0; msr[i] = 0; mserve[i] = 1; mleft[i] = 0; mwin[i] = 0;
            end else begin
                case (md[i])
                    0: if (en) md[i] = 1;
                    1: begin
                        if (!en) md[i] = 0;
                        else if (fl != fr) begin
                            if (fr) begin
                                msl[i] = (msl[i] < 31) ? msl[i] + 1 : 31;
                                mserve[i] = 1;
                            end else begin
                                msr[i] = (msr[i] < 31) ? msr[i] + 1 : 31;
                                mserve[i] = 0;
                            end
                            md[i] = 2;
                            mleft[i] = p_fc[i];
                        end
                    end
                    2: begin
                        if (!en) md[i] = 0;
                        else begin
                            mleft[i]--;
                            if (mleft[i] == 0) begin
                                m = (p_wm[i] == 0) ? 1 : p_wm[i];
                                if (msl[i] >= p_ws[i] && msl[i] - msr[i] >= m) begin
                                    md[i] = 3; mwin[i] = 1;
                                end else if (msr[i] >= p_ws[i] && msr[i] - msl[i] >= m) begin
                                    md[i] = 3; mwin[i] = 0;
                                end else begin
                                    md[i] = 1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("score_left[%0d]", i),  32'(o_vec[i][14:10]), msl[i]);
            chk($sformatf("score_right[%0d]", i), 32'(o_vec[i][9:5]),  msr[i]);
            chk($sformatf("flag_point[%0d]", i),  32'(o_vec[i][4]), 32'(md[i] == 2));
            chk($sformatf("freeze[%0d]", i),      32'(o_vec[i][3]), 32'(md[i] != 1));
            chk($sformatf("serve_left[%0d]", i),  32'(o_vec[i][2]), mserve[i]);
            chk($sformatf("endgame[%0d]", i),     32'(o_vec[i][1]), 32'(md[i] == 3));
            chk($sformatf("winner_left[%0d]", i), 32'(o_vec[i][0]), mwin[i]);
        end
    endtask

    task automatic cycle(input logic e, input logic r, input logic l, input logic rr);
        en = e; rg = r; fl = l; fr = rr;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    // Score one point on dut_a and wait (bounded) for its freeze to end.
    task automatic point(input logic l, input logic rr);
        int k;
        cycle(1'b1, 1'b0, l, rr);
        for (k = 0; k < 20; k++) begin
            if (!bus_a.flag_point) break;
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
        end
        if (k == 20) chk("point_timeout", 32'(bus_a.flag_point), 0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            md[i] = 0; msl[i] = 0; msr[i] = 0; mserve[i] = 1; mleft[i] = 0; mwin[i] = 0;
        end

        rst = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("rst_scores", 32'({bus_a.score_left, bus_a.score_right}), 0);
        chk("rst_freeze", 32'(bus_a.freeze), 1);
        chk("rst_serve", 32'(bus_a.serve_left), 1);
        chk("rst_endgame", 32'(bus_a.endgame), 0);

        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("play_freeze", 32'(bus_a.freeze), 0);

        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        chk("pt_score_right", 32'(bus_a.score_right), 1);
        chk("pt_serve", 32'(bus_a.serve_left), 0);
        chk("pt_flag", 32'(bus_a.flag_point), 1);
        chk("pt_freeze", 32'(bus_a.freeze), 1);
        n = 1;
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 1'b0, 1'b0, k == 0);
            if (!bus_a.flag_point) break;
            n++;
        end
        chk("flag_len", n, 4);
        chk("freeze_fall", 32'(bus_a.freeze), 0);
        chk("ignored_pulse", 32'(bus_a.score_left), 0);
        chk("b_endgame", 32'(bus_b.endgame), 1);
        chk("b_winner", 32'(bus_b.winner_left), 0);

        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        chk("both_scores", 32'({bus_a.score_left, bus_a.score_right}), 32'({5'd0, 5'd1}));
        chk("both_flag", 32'(bus_a.flag_point), 0);
        chk("both_freeze", 32'(bus_a.freeze), 0);

        point(1'b0, 1'b1);
        point(1'b0, 1'b1);
        point(1'b1, 1'b0);
        point(1'b0, 1'b1);
        chk("l3r2_scores", 32'({bus_a.score_left, bus_a.score_right}), 32'({5'd3, 5'd2}));
        chk("l3r2_endgame", 32'(bus_a.endgame), 0);
        point(1'b0, 1'b1);
        chk("win_endgame", 32'(bus_a.endgame), 1);
        chk("win_winner", 32'(bus_a.winner_left), 1);
        chk("win_flag", 32'(bus_a.flag_point), 0);
        chk("win_freeze", 32'(bus_a.freeze), 1);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        chk("over_scores", 32'({bus_a.score_left, bus_a.score_right}), 32'({5'd4, 5'd2}));
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("over_en_fall", 32'(bus_a.endgame), 1);

        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("rg_over_endgame", 32'(bus_a.endgame), 0);
        chk("rg_over_scores", 32'({bus_a.score_left, bus_a.score_right}), 0);
        chk("rg_over_freeze", 32'(bus_a.freeze), 1);

        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("rg_point_flag", 32'(bus_a.flag_point), 0);
        chk("rg_point_freeze", 32'(bus_a.freeze), 1);
        chk("rg_point_scores", 32'({bus_a.score_left, bus_a.score_right}), 0);

        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("en_fall_score", 32'(bus_a.score_left), 1);
        chk("en_fall_flag", 32'(bus_a.flag_point), 0);
        chk("en_fall_freeze", 32'(bus_a.freeze), 1);

        for (int k = 0; k < 6000; k++) begin
            rst = ($urandom_range(0, 999) < 2);
            cycle($urandom_range(0, 99) < 98, $urandom_range(0, 999) < 2,
                  $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 20);
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Match scoring and rally sequencing stage directly upstream of the menu/overlay block.
- Consumes ball-floor contact pulses from the ball physics stage and produces the two signals that the menu/overlay stage reads: flag_point (point-scored overlay) and endgame (game-over overlay and menu re-arm).
- Also emits the rally freeze and serve side back to physics, plus the live score for the scoreboard text generator.

Parameters:
- WIN_SCORE, 15, points a player needs to win; legal range 1..31.
- WIN_MARGIN, 2, minimum lead needed to win; a value of 0 behaves as 1.
- FREEZE_CYCLES, 65_000_000, number of clk cycles the rally stays frozen after a point (1 s at 65 MHz); must be at least 1.
- CNT_W, 26, width of the freeze counter; must satisfy 2^CNT_W > FREEZE_CYCLES.

Ports:
- clk  in  1  pixel/system clock
- rst  in  1  synchronous, active-high reset
- enable_game  in  1  level; high while a match is active (menu dismissed)
- reset_game  in  1  level from the menu stage; while high, clears the match
- floor_left  in  1  one-cycle pulse: ball touched the floor on the left half
- floor_right  in  1  one-cycle pulse: ball touched the floor on the right half
- score_left  out  5  left player score
- score_right  out  5  right player score
- flag_point  out  1  high during the post-point freeze
- freeze  out  1  physics hold request
- serve_left  out  1  1 = left player serves next rally
- endgame  out  1  match finished
- winner_left  out  1  valid while endgame=1; 1 = left player won

Behaviour:
- All outputs are registered and change only on the rising edge of clk.
- rst=1 or reset_game=1 forces on the next edge:
  - state=IDLE;
  - scores=0, counter=0;
  - flag_point=0, freeze=1, endgame=0, winner_left=0, serve_left=1.
  - rst has priority over every other input.
- States:
  - IDLE: freeze=1. Moves to PLAY on the first edge with enable_game=1.
  - PLAY: freeze=0.
    - floor_right alone: score_left+1, serve_left=1, go to POINT.
    - floor_left alone: score_right+1, serve_right (serve_left=0), go to POINT.
    - Both pulses in the same cycle, or neither: no change.
    - Scoring latency: score, serve_left, flag_point and freeze all update on the edge that samples the pulse.
  - POINT: flag_point=1, freeze=1. The counter starts at 0 on entry and increments every cycle; floor pulses are ignored.
    - On the edge where the counter equals FREEZE_CYCLES-1, evaluate the winner using the updated scores.
    - Win condition for a side: its score >= WIN_SCORE and its score - other score >= max(WIN_MARGIN,1).
    - If a side wins: go to OVER, endgame=1, winner_left set accordingly, flag_point=0.
    - Otherwise: go to PLAY, flag_point=0, freeze=0.
    - flag_point is therefore high for exactly FREEZE_CYCLES cycles.
  - OVER: endgame=1, freeze=1, scores held. Leaves only on rst or reset_game, both of which go to IDLE.
- enable_game falling in PLAY or POINT: go to IDLE with scores retained, the counter cleared, flag_point=0 and freeze=1.
- enable_game falling in OVER: no effect; the state stays OVER.
- Score arithmetic is 5-bit and saturates at 31. Once the cap is reached, further increments are dropped.
- The difference compare uses 6-bit signed arithmetic, so no wrap-around error is possible.
- Outputs are mutually consistent: endgame=1 implies flag_point=0 and freeze=1.

Test Plan:
- rst for 2 cycles, then enable_game=1 -> IDLE, then PLAY one edge later; scores 0/0, serve_left=1, endgame=0, freeze drops to 0 on the PLAY edge.
- FREEZE_CYCLES=4: pulse floor_left in PLAY -> next edge score_right=1, serve_left=0, flag_point=1 for exactly 4 cycles; freeze falls on the same edge as flag_point; a floor_right pulse during the freeze is ignored.
- floor_left and floor_right pulsed in the same cycle -> scores unchanged, state stays PLAY, flag_point stays 0.
- WIN_SCORE=3, WIN_MARGIN=2: drive left to 3, right to 2 -> no endgame; then left reaches 4 -> endgame=1, winner_left=1 at the end of the freeze; further pulses ignored.
- WIN_MARGIN=0 with WIN_SCORE=1: first point -> endgame after the freeze.
- Assert reset_game while in OVER, then while mid-POINT (counter=2) -> next edge IDLE, scores 0/0, endgame=0, flag_point=0, freeze=1.
